// File: rtl/tape_recorder.sv
// Cassette capture path: decodes the MC-10 tape square wave into bytes by full-period
// measurement and queues them, with incrementing SDRAM addresses, for the SDRAM writer.
module tape_recorder #(
    parameter int          FILT_LEN   = 64,
    parameter int          MIN_PERIOD = 4000,
    parameter int          BIT_THRESH = 26667,
    parameter int          TIMEOUT    = 106667,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [22:0] BASE_ADDR  = 23'h040000
) (
    input  logic        clk_video,
    input  logic        reset,
    input  logic        rec_en,
    input  logic        tape_in,
    output logic        wr_req,
    output logic [7:0]  wr_data,
    output logic [22:0] wr_addr,
    input  logic        wr_ack,
    output logic [15:0] byte_count,
    output logic        overflow,
    output logic        active
);

    localparam int              FCW       = $clog2(FILT_LEN) + 1;
    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam logic [FCW-1:0]  FILT_LAST = FCW'(FILT_LEN - 1);
    localparam logic [16:0]     MIN_C     = 17'(MIN_PERIOD);
    localparam logic [16:0]     THR_C     = 17'(BIT_THRESH);
    localparam logic [16:0]     TMO_C     = 17'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    logic           tape_s1_r, tape_s2_r;
    logic           filt_r;
    logic [FCW-1:0] filt_cnt_r;
    logic           rise_s;
    state_t         state_r;
    logic [16:0]    per_cnt_r;
    logic [2:0]     bit_cnt_r;
    logic [7:0]     shift_r;
    logic [7:0]     next_shift_s;
    logic           push_r;
    logic [7:0]     push_data_r;
    logic           rec_en_d_r;
    logic           start_s;
    logic           flush_s;
    logic [AW:0]    wptr_r, rptr_r;
    logic [AW:0]    count_s;
    logic           empty_s, full_s, pop_s, push_ok_s;
    logic [7:0]     mem_r [FIFO_DEPTH];
    logic [22:0]    wr_addr_r;
    logic [15:0]    byte_count_r;
    logic           overflow_r;

    // The filtered level flips on the FILT_LEN-th consecutive cycle of disagreement,
    // so a rising edge is exactly that flip from 0 to 1.
    assign rise_s       = tape_s2_r & ~filt_r & (filt_cnt_r == FILT_LAST);
    assign next_shift_s = {(per_cnt_r < THR_C), shift_r[7:1]};
    assign start_s      = rec_en & ~rec_en_d_r;
    assign flush_s      = (state_r == ST_IDLE) & start_s;

    // Two-stage synchronizer followed by the stability filter.
    always_ff @(posedge clk_video) begin
        if (reset) begin
            tape_s1_r  <= 1'b0;
            tape_s2_r  <= 1'b0;
            filt_r     <= 1'b0;
            filt_cnt_r <= '0;
        end else begin
            tape_s1_r <= tape_in;
            tape_s2_r <= tape_s1_r;
            if (tape_s2_r != filt_r) begin
                if (filt_cnt_r == FILT_LAST) begin
                    filt_r     <= tape_s2_r;
                    filt_cnt_r <= '0;
                end else begin
                    filt_cnt_r <= filt_cnt_r + 1'b1;
                end
            end else begin
                filt_cnt_r <= '0;
            end
        end
    end

    // Recording FSM, period counter and LSB-first byte assembly.
    always_ff @(posedge clk_video) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            per_cnt_r   <= '0;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            push_r      <= 1'b0;
            push_data_r <= 8'h00;
            rec_en_d_r  <= 1'b0;
        end else begin
            rec_en_d_r <= rec_en;
            push_r     <= 1'b0;
            if (per_cnt_r != TMO_C) begin
                per_cnt_r <= per_cnt_r + 17'd1;
            end
            if (!rec_en) begin
                state_r   <= ST_IDLE;
                per_cnt_r <= '0;
                bit_cnt_r <= 3'd0;
                shift_r   <= 8'h00;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        per_cnt_r <= '0;
                        bit_cnt_r <= 3'd0;
                        shift_r   <= 8'h00;
                        if (start_s) begin
                            state_r <= ST_SYNC;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_SYNC: begin
                        if (rise_s) begin
                            per_cnt_r <= '0;
                            state_r   <= ST_MEASURE;
                        end else begin
                            state_r <= ST_SYNC;
                        end
                    end
                    ST_MEASURE: begin
                        // A gap wins over a coincident edge: the partial byte is dropped.
                        if (per_cnt_r == TMO_C) begin
                            bit_cnt_r <= 3'd0;
                            state_r   <= ST_SYNC;
                        end else if (rise_s && (per_cnt_r >= MIN_C)) begin
                            per_cnt_r <= '0;
                            shift_r   <= next_shift_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                push_r      <= 1'b1;
                                push_data_r <= next_shift_s;
                            end else begin
                                push_r <= 1'b0;
                            end
                        end else begin
                            state_r <= ST_MEASURE;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign count_s   = wptr_r - rptr_r;
    assign empty_s   = (wptr_r == rptr_r);
    assign full_s    = count_s[AW];
    assign pop_s     = wr_ack & ~empty_s;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
    assign push_ok_s = push_r & (~full_s | pop_s);

    // FIFO pointers, write address, accepted-byte counter and sticky overflow.
    always_ff @(posedge clk_video) begin
        if (reset || flush_s) begin
            wptr_r       <= '0;
            rptr_r       <= '0;
            wr_addr_r    <= BASE_ADDR;
            byte_count_r <= 16'h0000;
            overflow_r   <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + 1'b1;
            end else if (push_r) begin
                overflow_r <= 1'b1;
            end
            if (pop_s) begin
                rptr_r    <= rptr_r + 1'b1;
                wr_addr_r <= wr_addr_r + 23'd1;
                if (byte_count_r != 16'hFFFF) begin
                    byte_count_r <= byte_count_r + 16'd1;
                end
            end
        end
    end

    // FIFO storage; contents need no reset because reads are gated by empty.
    always_ff @(posedge clk_video) begin
        if (push_ok_s && !flush_s && !reset) begin
            mem_r[wptr_r[AW-1:0]] <= push_data_r;
        end
    end

    assign wr_req     = ~empty_s;
    assign wr_data    = empty_s ? 8'h00 : mem_r[rptr_r[AW-1:0]];
    assign wr_addr    = wr_addr_r;
    assign byte_count = byte_count_r;
    assign overflow   = overflow_r;
    assign active     = (state_r == ST_MEASURE);

endmodule

// File: tb/tb_tape_recorder.sv
// Scoreboard bench for tape_recorder with time-scaled parameters: a 1-cycle is 100 clocks
// and a 0-cycle 200 clocks; expected bytes are queued as sent and checked on wr_req.
module tb_tape_recorder;

    localparam int          FILT_LEN   = 8;
    localparam int          MIN_PERIOD = 30;
    localparam int          BIT_THRESH = 150;
    localparam int          TIMEOUT    = 600;
    localparam logic [22:0] BASE       = 23'h040000;

    logic        clk_video = 1'b0;
    logic        reset     = 1'b1;
    logic        rec_en    = 1'b0;
    logic        tape_in   = 1'b0;
    logic        wr_ack    = 1'b0;
    logic        wr_req;
    logic [7:0]  wr_data;
    logic [22:0] wr_addr;
    logic [15:0] byte_count;
    logic        overflow;
    logic        active;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  sb_q[$];
    logic [22:0] mdl_addr  = BASE;
    logic [15:0] mdl_count = 16'd0;
    bit          ack_en    = 1'b0;

    tape_recorder #(
        .FILT_LEN  (FILT_LEN),
        .MIN_PERIOD(MIN_PERIOD),
        .BIT_THRESH(BIT_THRESH),
        .TIMEOUT   (TIMEOUT),
        .FIFO_DEPTH(16),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_video (clk_video),
        .reset     (reset),
        .rec_en    (rec_en),
        .tape_in   (tape_in),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .wr_addr   (wr_addr),
        .wr_ack    (wr_ack),
        .byte_count(byte_count),
        .overflow  (overflow),
        .active    (active)
    );

    always #5 clk_video = ~clk_video;

    // Writer model: checks the head byte and address, then acks 3 cycles later.
    initial begin
        logic [7:0] exp_d;
        forever begin
            @(negedge clk_video);
            if (ack_en && wr_req === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %h expected none", wr_data);
                end else begin
                    exp_d = sb_q.pop_front();
                    if (wr_data !== exp_d) begin
                        errors++;
                        $display("FAIL wr_data: got %h expected %h", wr_data, exp_d);
                    end
                end
                checks++;
                if (wr_addr !== mdl_addr) begin
                    errors++;
                    $display("FAIL wr_addr: got %h expected %h", wr_addr, mdl_addr);
                end
                repeat (3) @(negedge clk_video);
                wr_ack = 1'b1;
                @(negedge clk_video);
                wr_ack    = 1'b0;
                mdl_addr  = mdl_addr + 23'd1;
                mdl_count = mdl_count + 16'd1;
            end
        end
    end

    task automatic send_cycle(input logic b);
        int half;
        half = b ? 50 : 100;
        tape_in = 1'b1;
        repeat (half) @(negedge clk_video);
        tape_in = 1'b0;
        repeat (half) @(negedge clk_video);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit expect_out);
        if (expect_out) sb_q.push_back(d);
        for (int i = 0; i < 8; i++) send_cycle(d[i]);
    endtask

    // Same bit timing, with sub-filter glitches and a too-early edge inside 0-cycles.
    task automatic send_byte_glitchy(input logic [7:0] d);
        sb_q.push_back(d);
        for (int i = 0; i < 8; i++) begin
            if (d[i]) begin
                tape_in = 1'b1; repeat (20) @(negedge clk_video);
                tape_in = 1'b0; repeat (3)  @(negedge clk_video);
                tape_in = 1'b1; repeat (27) @(negedge clk_video);
                tape_in = 1'b0; repeat (20) @(negedge clk_video);
                tape_in = 1'b1; repeat (3)  @(negedge clk_video);
                tape_in = 1'b0; repeat (27) @(negedge clk_video);
            end else begin
                tape_in = 1'b1; repeat (10) @(negedge clk_video);
                tape_in = 1'b0; repeat (10) @(negedge clk_video);
                tape_in = 1'b1; repeat (80) @(negedge clk_video);
                tape_in = 1'b0; repeat (40) @(negedge clk_video);
                tape_in = 1'b1; repeat (3)  @(negedge clk_video);
                tape_in = 1'b0; repeat (57) @(negedge clk_video);
            end
        end
    endtask

    // Closing edge for the last bit, then silence long enough to time out.
    task automatic end_stream();
        tape_in = 1'b1;
        repeat (50) @(negedge clk_video);
        tape_in = 1'b0;
        repeat (700) @(negedge clk_video);
    endtask

    task automatic start_rec();
        rec_en = 1'b0;
        repeat (3) @(negedge clk_video);
        sb_q.delete();
        mdl_addr  = BASE;
        mdl_count = 16'd0;
        rec_en    = 1'b1;
        repeat (3) @(negedge clk_video);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || wr_req === 1'b1) && n < 3000) begin
            @(negedge clk_video);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s_drain: got %0d bytes left expected 0", name, sb_q.size());
        end
        repeat (2) @(negedge clk_video);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk_video);
        check_val("rst_wr_req", {31'd0, wr_req}, 32'd0);
        check_val("rst_wr_data", {24'd0, wr_data}, 32'd0);
        check_val("rst_wr_addr", {9'd0, wr_addr}, {9'd0, BASE});
        check_val("rst_byte_count", {16'd0, byte_count}, 32'd0);
        check_val("rst_overflow", {31'd0, overflow}, 32'd0);
        check_val("rst_active", {31'd0, active}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk_video);
    endtask

    task automatic test_basic_byte();
        ack_en = 1'b1;
        start_rec();
        send_byte(8'hA5, 1'b1);
        end_stream();
        wait_drain("basic");
        check_val("basic_byte_count", {16'd0, byte_count}, 32'd1);
        check_val("basic_wr_addr", {9'd0, wr_addr}, {9'd0, 23'h040001});
    endtask

    task automatic test_glitch_back_to_back();
        send_byte_glitchy(8'h3C);
        send_byte_glitchy(8'hC3);
        check_val("glitch_active", {31'd0, active}, 32'd1);
        end_stream();
        wait_drain("glitch");
        check_val("glitch_byte_count", {16'd0, byte_count}, {16'd0, mdl_count});
        check_val("glitch_count_abs", {16'd0, byte_count}, 32'd3);
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 5; i++) send_cycle(1'b1);
        check_val("timeout_active_during", {31'd0, active}, 32'd1);
        repeat (400) @(negedge clk_video);
        check_val("timeout_active_before", {31'd0, active}, 32'd1);
        repeat (200) @(negedge clk_video);
        check_val("timeout_active_after", {31'd0, active}, 32'd0);
        check_val("timeout_no_byte", {31'd0, wr_req}, 32'd0);
        send_byte(8'h96, 1'b1);
        end_stream();
        wait_drain("timeout");
        check_val("timeout_byte_count", {16'd0, byte_count}, 32'd4);
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        ack_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            d = 8'(i * 37 + 5);
            send_byte(d, i < 16);
        end
        end_stream();
        check_val("ovf_sticky", {31'd0, overflow}, 32'd1);
        check_val("ovf_wr_req", {31'd0, wr_req}, 32'd1);
        check_val("ovf_no_drain_yet", {16'd0, byte_count}, 32'd4);
        start_rec_keep();
        ack_en = 1'b1;
        wait_drain("ovf");
        check_val("ovf_byte_count", {16'd0, byte_count}, 32'd20);
        check_val("ovf_still_set", {31'd0, overflow}, 32'd1);
    endtask

    // Counting continues within the same recording; only the model is told so.
    task automatic start_rec_keep();
        mdl_count = byte_count === 16'd4 ? 16'd4 : mdl_count;
    endtask

    task automatic test_rec_toggle();
        ack_en = 1'b0;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        for (int i = 0; i < 4; i++) send_cycle(1'b1);
        check_val("tog_pre_wr_req", {31'd0, wr_req}, 32'd1);
        check_val("tog_pre_overflow", {31'd0, overflow}, 32'd1);
        rec_en = 1'b0;
        repeat (3) @(negedge clk_video);
        rec_en = 1'b1;
        repeat (2) @(negedge clk_video);
        check_val("tog_wr_req", {31'd0, wr_req}, 32'd0);
        check_val("tog_wr_addr", {9'd0, wr_addr}, {9'd0, BASE});
        check_val("tog_byte_count", {16'd0, byte_count}, 32'd0);
        check_val("tog_overflow", {31'd0, overflow}, 32'd0);
        sb_q.delete();
        mdl_addr  = BASE;
        mdl_count = 16'd0;
        ack_en    = 1'b1;
        send_byte(8'h69, 1'b1);
        end_stream();
        wait_drain("tog");
        check_val("tog_after_count", {16'd0, byte_count}, 32'd1);
        check_val("tog_after_addr", {9'd0, wr_addr}, {9'd0, 23'h040001});
    endtask

    task automatic test_reset_mid_byte();
        ack_en = 1'b0;
        send_byte(8'h5A, 1'b0);
        for (int i = 0; i < 3; i++) send_cycle(1'b0);
        check_val("mid_pre_wr_req", {31'd0, wr_req}, 32'd1);
        check_val("mid_pre_active", {31'd0, active}, 32'd1);
        reset = 1'b1;
        @(negedge clk_video);
        check_val("mid_wr_req", {31'd0, wr_req}, 32'd0);
        check_val("mid_wr_data", {24'd0, wr_data}, 32'd0);
        check_val("mid_wr_addr", {9'd0, wr_addr}, {9'd0, BASE});
        check_val("mid_byte_count", {16'd0, byte_count}, 32'd0);
        check_val("mid_active", {31'd0, active}, 32'd0);
        reset = 1'b0;
        repeat (300) @(negedge clk_video);
        check_val("mid_no_late_write", {31'd0, wr_req}, 32'd0);
    endtask

    initial begin
        test_reset();
        test_basic_byte();
        test_glitch_back_to_back();
        test_timeout();
        test_overflow();
        test_rec_toggle();
        test_reset_mid_byte();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
